// File: rtl/apu_cluster_package.sv
// -----------------------------------------------------------------------------
// apu_cluster_package
//   Shared constants and types for the APU cluster.
//   Used here by the integer-divider result buffer (int_div_resbuf).
//
//   Contents:
//     NUSFLAGS_INT_DIV      number of status flags produced by the integer divider
//     INT_DIV_RESBUF_DEPTH  default number of result slots in int_div_resbuf
//     int_div_res_t         divider result payload {res, status}. The request tag
//                           is not part of this type because its width is a
//                           per-instance parameter.
// -----------------------------------------------------------------------------
package apu_cluster_package;

    // Divider status flags: divide-by-zero and signed overflow.
    localparam int NUSFLAGS_INT_DIV = 2;

    localparam int INT_DIV_RESBUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0]                 res;
        logic [NUSFLAGS_INT_DIV-1:0] status;
    } int_div_res_t;

endpackage : apu_cluster_package

// File: rtl/int_div_resbuf.sv
// -----------------------------------------------------------------------------
// int_div_resbuf
//   Result buffer placed directly after the shared iterative integer divider.
//   The divider emits each result as a single-cycle pulse and cannot be stalled.
//   This block captures every result, status and tag in a small FIFO. It then
//   offers them in order to the cluster response interconnect.
//   It also hands the issue logic a credit (IssueOk_o). A divide is therefore
//   only launched when a result slot is guaranteed to be free.
//
//   Optional feature (compile-time macro INT_DIV_RESBUF_BYPASS_EN):
//     defined   - when the FIFO is empty, an arriving result is shown on the
//                 outputs in the same cycle. If the consumer takes it in that
//                 cycle it is never written to the FIFO.
//     undefined - outputs depend on registered state only; 1-cycle latency.
//
//   Ports:
//     clk_i        in   clock
//     rst_ni       in   asynchronous active-low reset
//     Issue_i      in   a divide is launched this cycle
//     IssueOk_o    out  a result slot can be reserved; issue only when 1
//     DivValid_i   in   divider result valid pulse
//     DivRes_i     in   [31:0] divider result
//     DivTag_i     in   [TAG_WIDTH-1:0] divider result tag
//     DivStatus_i  in   [STAT_WIDTH-1:0] divider status flags
//     Valid_o      out  head entry valid to consumer
//     Ready_i      in   consumer accepts head entry
//     Res_o        out  [31:0] head result ('0 when empty)
//     Tag_o        out  [TAG_WIDTH-1:0] head tag ('0 when empty)
//     Status_o     out  [STAT_WIDTH-1:0] head status ('0 when empty)
//     Error_o      out  sticky protocol-error flag, cleared only by reset
//
//   Handshake: a transfer happens on every rising clock edge where
//   Valid_o & Ready_i. While Valid_o is high and Ready_i is low, the head
//   entry (Res_o/Tag_o/Status_o) is held stable. Valid_o never drops without
//   a transfer.
// -----------------------------------------------------------------------------
module int_div_resbuf
    import apu_cluster_package::*;
#(
    parameter int DEPTH      = INT_DIV_RESBUF_DEPTH,
    parameter int TAG_WIDTH  = 1,
    parameter int STAT_WIDTH = NUSFLAGS_INT_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Issue_i,
    output logic                  IssueOk_o,
    input  logic                  DivValid_i,
    input  logic [31:0]           DivRes_i,
    input  logic [TAG_WIDTH-1:0]  DivTag_i,
    input  logic [STAT_WIDTH-1:0] DivStatus_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [31:0]           Res_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    output logic                  Error_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW:0]   CRED_MAX = (CW + 1)'(DEPTH);

    // Storage: plain register array, one row per slot.
    logic [31:0]           mem_res    [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag    [DEPTH];
    logic [STAT_WIDTH-1:0] mem_status [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          error_q;

    logic fifo_valid;
    logic fifo_full;
    logic issue_ok;
    logic issue_acc;
    logic pop;
    logic bypass_take;
    logic push_req;
    logic push_ok;
    logic push_drop;
    logic orphan_res;

    // Credit: stored results plus results still inside the divider must fit.
    assign issue_ok   = ({1'b0, count} + {1'b0, inflight}) < CRED_MAX;
    assign issue_acc  = Issue_i & issue_ok;

    assign fifo_valid = (count != '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = fifo_valid & Ready_i;

`ifdef INT_DIV_RESBUF_BYPASS_EN
    // Empty FIFO and the consumer is ready: hand the result straight through.
    assign bypass_take = ~fifo_valid & DivValid_i & Ready_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign push_req   = DivValid_i & ~bypass_take;
    // A full FIFO can accept a push only when the head leaves in the same cycle.
    assign push_ok    = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;
    // A result that no issue ever reserved a slot for.
    assign orphan_res = DivValid_i & (inflight == '0);

    // ------------------------------------------------------------------
    // Pointers, occupancy, credit and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            error_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end

            // An accepted issue and a returning result cancel each other out.
            if (issue_acc && DivValid_i) begin
                inflight <= inflight;
            end else if (issue_acc) begin
                inflight <= inflight + CW'(1);
            end else if (DivValid_i && (inflight != '0)) begin
                inflight <= inflight - CW'(1);
            end

            if ((Issue_i && !issue_ok) || orphan_res || push_drop) begin
                error_q <= 1'b1;
            end
        end
    end

    // Storage rows carry no reset; rows are only read while count says they
    // hold data.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_res[wr_ptr]    <= DivRes_i;
            mem_tag[wr_ptr]    <= DivTag_i;
            mem_status[wr_ptr] <= DivStatus_i;
        end
    end

    // ------------------------------------------------------------------
    // Output selection
    // ------------------------------------------------------------------
    always_comb begin
        Valid_o  = 1'b0;
        Res_o    = '0;
        Tag_o    = '0;
        Status_o = '0;
        if (fifo_valid) begin
            Valid_o  = 1'b1;
            Res_o    = mem_res[rd_ptr];
            Tag_o    = mem_tag[rd_ptr];
            Status_o = mem_status[rd_ptr];
        end
`ifdef INT_DIV_RESBUF_BYPASS_EN
        else if (DivValid_i) begin
            Valid_o  = 1'b1;
            Res_o    = DivRes_i;
            Tag_o    = DivTag_i;
            Status_o = DivStatus_i;
        end
`endif
    end

    assign IssueOk_o = issue_ok;
    assign Error_o   = error_q;

endmodule : int_div_resbuf
